// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer and the condition stage.
package pc_sequencer_pkg;

  localparam int unsigned COND_W  = 2;
  localparam int unsigned STATE_W = 2;

  // Branch condition codes, shared with the condition-evaluation stage
  localparam logic [COND_W-1:0] COND_GT = 2'b00;
  localparam logic [COND_W-1:0] COND_LT = 2'b01;
  localparam logic [COND_W-1:0] COND_EQ = 2'b10;
  localparam logic [COND_W-1:0] COND_AL = 2'b11;

  // Sequencer FSM encodings
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE   = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESOLVE = 2'd2;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment when enabled, sticking at all-ones
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and branch resolution: RUN -> ISSUE -> RESOLVE per branch.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic              is_branch,
  input  logic [1:0]        cond_code,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [1:0]        cond_sel,
  input  logic              cond_true,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              flush,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  taken_count
);

  logic [STATE_W-1:0] state_q,        state_d;
  logic [ADDR_W-1:0]  pc_q,           pc_d;
  logic [ADDR_W-1:0]  target_q,       target_d;
  logic [COND_W-1:0]  cond_sel_q,     cond_sel_d;
  logic               branch_taken_q, branch_taken_d;
  logic               cnt_en;

  // Next-state and datapath updates
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    target_d       = target_q;
    cond_sel_d     = cond_sel_q;
    branch_taken_d = 1'b0;
    cnt_en         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall && instr_valid) begin
          if (is_branch) begin
            cond_sel_d = cond_code;
            target_d   = branch_target;
            state_d    = ST_ISSUE;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        // Condition stage samples cond_sel at the end of this cycle
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (cond_true) begin
          pc_d           = target_q;
          branch_taken_d = 1'b1;
          cnt_en         = 1'b1;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      target_q       <= '0;
      cond_sel_q     <= COND_AL;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      target_q       <= target_d;
      cond_sel_q     <= cond_sel_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .count   (taken_count)
  );

  assign pc           = pc_q;
  assign cond_sel     = cond_sel_q;
  assign branch_taken = branch_taken_q;
  assign fetch_en     = (state_q == ST_RUN) && !stall;
  assign flush        = (state_q == ST_ISSUE) || (state_q == ST_RESOLVE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, CNT_W=2 to reach saturation quickly).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       stall;
  logic       instr_valid;
  logic       is_branch;
  logic [1:0] cond_code;
  logic [7:0] branch_target;
  logic [1:0] cond_sel;
  logic       cond_true;
  logic [7:0] pc;
  logic       fetch_en;
  logic       flush;
  logic       branch_taken;
  logic [1:0] taken_count;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .is_branch     (is_branch),
    .cond_code     (cond_code),
    .branch_target (branch_target),
    .cond_sel      (cond_sel),
    .cond_true     (cond_true),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .taken_count   (taken_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    stall = 0; instr_valid = 0; is_branch = 0; cond_code = 2'b00;
    branch_target = 8'h00; cond_true = 0;
  endtask

  // Drive one full branch with no checking (used to position state)
  task automatic run_branch(input logic [1:0] code, input logic [7:0] tgt, input logic ct);
    instr_valid = 1; is_branch = 1; cond_code = code; branch_target = tgt;
    tick;
    instr_valid = 0; is_branch = 0;
    tick;
    cond_true = ct;
    tick;
    cond_true = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_n = 0;
    tick;
    reset_n = 1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got %0h exp 00", pc); end
    checks++; if (cond_sel !== 2'b11) begin failures++; $display("FAIL reset_cond_sel got %0b exp 11", cond_sel); end
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got %0b exp 0", branch_taken); end
    checks++; if (taken_count !== 2'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", taken_count); end
    checks++; if ({fetch_en, flush} !== 2'b10) begin failures++; $display("FAIL reset_fetch_flush got %0b exp 10", {fetch_en, flush}); end
  endtask

  task automatic test_sequential;
    instr_valid = 1; is_branch = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      checks++; if (pc !== 8'(i)) begin failures++; $display("FAIL seq_pc step %0d got %0h exp %0h", i, pc, i); end
      checks++; if ({fetch_en, flush} !== 2'b10) begin failures++; $display("FAIL seq_fetch_flush got %0b exp 10", {fetch_en, flush}); end
    end
    instr_valid = 0;
  endtask

  task automatic test_branch_taken;
    instr_valid = 1; tick; instr_valid = 0;
    checks++; if (pc !== 8'h05) begin failures++; $display("FAIL bt_start_pc got %0h exp 05", pc); end
    instr_valid = 1; is_branch = 1; cond_code = 2'b11; branch_target = 8'h40;
    tick;
    instr_valid = 0; is_branch = 0; branch_target = 8'h99;
    checks++; if ({flush, fetch_en, pc} !== {1'b1, 1'b0, 8'h05}) begin failures++; $display("FAIL bt_issue got fl=%0b fe=%0b pc=%0h exp fl=1 fe=0 pc=05", flush, fetch_en, pc); end
    checks++; if (cond_sel !== 2'b11) begin failures++; $display("FAIL bt_cond_sel got %0b exp 11", cond_sel); end
    tick;
    checks++; if ({flush, pc, branch_taken} !== {1'b1, 8'h05, 1'b0}) begin failures++; $display("FAIL bt_resolve got fl=%0b pc=%0h bt=%0b exp fl=1 pc=05 bt=0", flush, pc, branch_taken); end
    cond_true = 1;
    tick;
    cond_true = 0;
    checks++; if ({flush, fetch_en, pc} !== {1'b0, 1'b1, 8'h40}) begin failures++; $display("FAIL bt_done got fl=%0b fe=%0b pc=%0h exp fl=0 fe=1 pc=40", flush, fetch_en, pc); end
    checks++; if ({branch_taken, taken_count} !== {1'b1, 2'd1}) begin failures++; $display("FAIL bt_pulse got bt=%0b cnt=%0d exp bt=1 cnt=1", branch_taken, taken_count); end
    tick;
    checks++; if ({branch_taken, pc} !== {1'b0, 8'h40}) begin failures++; $display("FAIL bt_pulse_end got bt=%0b pc=%0h exp bt=0 pc=40", branch_taken, pc); end
  endtask

  task automatic test_wrap;
    run_branch(2'b11, 8'hFF, 1'b1);
    tick;
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL wrap_setup_pc got %0h exp ff", pc); end
    instr_valid = 1; tick; instr_valid = 0;
    checks++; if ({pc, branch_taken, taken_count, cond_sel, fetch_en, flush} !== {8'h00, 1'b0, 2'd2, 2'b11, 1'b1, 1'b0})
      begin failures++; $display("FAIL wrap got pc=%0h bt=%0b cnt=%0d cs=%0b fe=%0b fl=%0b exp pc=00 bt=0 cnt=2 cs=11 fe=1 fl=0",
                                 pc, branch_taken, taken_count, cond_sel, fetch_en, flush); end
  endtask

  task automatic test_branch_not_taken;
    do_reset();
    instr_valid = 1;
    repeat (5) tick;
    instr_valid = 0;
    checks++; if (pc !== 8'h05) begin failures++; $display("FAIL bnt_start_pc got %0h exp 05", pc); end
    instr_valid = 1; is_branch = 1; cond_code = 2'b10; branch_target = 8'h40;
    tick;
    instr_valid = 0; is_branch = 0;
    checks++; if ({cond_sel, flush} !== {2'b10, 1'b1}) begin failures++; $display("FAIL bnt_issue got cs=%0b fl=%0b exp cs=10 fl=1", cond_sel, flush); end
    tick;
    cond_true = 0;
    tick;
    checks++; if ({pc, branch_taken, taken_count, flush} !== {8'h06, 1'b0, 2'd0, 1'b0})
      begin failures++; $display("FAIL bnt_done got pc=%0h bt=%0b cnt=%0d fl=%0b exp pc=06 bt=0 cnt=0 fl=0", pc, branch_taken, taken_count, flush); end
    tick;
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL bnt_no_pulse got %0b exp 0", branch_taken); end
  endtask

  task automatic test_stall;
    stall = 1; instr_valid = 1; is_branch = 1; cond_code = 2'b01; branch_target = 8'h20;
    #1;
    checks++; if ({fetch_en, flush} !== 2'b00) begin failures++; $display("FAIL stall_run_fetch got %0b exp 00", {fetch_en, flush}); end
    tick;
    checks++; if ({pc, flush, cond_sel} !== {8'h06, 1'b0, 2'b10}) begin failures++; $display("FAIL stall_hold got pc=%0h fl=%0b cs=%0b exp pc=06 fl=0 cs=10", pc, flush, cond_sel); end
    stall = 0;
    tick;
    instr_valid = 0; is_branch = 0;
    stall = 1;
    #1;
    checks++; if ({cond_sel, flush, fetch_en} !== {2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL stall_issue got cs=%0b fl=%0b fe=%0b exp cs=01 fl=1 fe=0", cond_sel, flush, fetch_en); end
    tick;
    cond_true = 1;
    tick;
    cond_true = 0;
    checks++; if ({pc, branch_taken, taken_count, fetch_en} !== {8'h20, 1'b1, 2'd1, 1'b0})
      begin failures++; $display("FAIL stall_resolve got pc=%0h bt=%0b cnt=%0d fe=%0b exp pc=20 bt=1 cnt=1 fe=0", pc, branch_taken, taken_count, fetch_en); end
    stall = 0;
  endtask

  task automatic test_reset_mid_branch;
    instr_valid = 1; is_branch = 1; cond_code = 2'b11; branch_target = 8'h77;
    tick;
    instr_valid = 0; is_branch = 0;
    tick;
    cond_true = 1; reset_n = 0;
    tick;
    reset_n = 1; cond_true = 0;
    checks++; if ({pc, branch_taken, taken_count, flush, fetch_en, cond_sel} !== {8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 2'b11})
      begin failures++; $display("FAIL rst_mid got pc=%0h bt=%0b cnt=%0d fl=%0b fe=%0b cs=%0b exp pc=00 bt=0 cnt=0 fl=0 fe=1 cs=11",
                                 pc, branch_taken, taken_count, flush, fetch_en, cond_sel); end
    tick;
    checks++; if ({pc, branch_taken} !== {8'h00, 1'b0}) begin failures++; $display("FAIL rst_mid_after got pc=%0h bt=%0b exp pc=00 bt=0", pc, branch_taken); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_branch(2'b00, 8'h10, 1'b1);
      checks++; if (taken_count !== exp_cnt[i]) begin failures++; $display("FAIL sat_count branch %0d got %0d exp %0d", i, taken_count, exp_cnt[i]); end
    end
    checks++; if (pc !== 8'h10) begin failures++; $display("FAIL sat_same_target_pc got %0h exp 10", pc); end
  endtask

  initial begin
    reset_n = 1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch_taken();
    test_wrap();
    test_branch_not_taken();
    test_stall();
    test_reset_mid_branch();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and branch-resolution stage directly downstream of the condition-evaluation stage.
- Advances the PC on every accepted non-branch instruction.
- On a branch, presents the 2-bit condition code to the condition stage, waits for its registered true/false result, then loads either the branch target or PC+1.
- Feeds the instruction fetch path and signals the front end to discard in-flight instructions while a branch resolves.

Parameters:
ADDR_W, 8, width of PC and branch target
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the taken-branch statistics counter

Ports:
clk  input  1  single system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
stall  input  1  freeze PC while in RUN
instr_valid  input  1  decoded instruction present this cycle
is_branch  input  1  decoded instruction is a branch (qualified by instr_valid)
cond_code  input  2  branch condition: 00 GT (not negative), 01 LT (negative), 10 EQ (zero), 11 always
branch_target  input  ADDR_W  absolute target address
cond_sel  output  2  registered condition code driven to the condition stage
cond_true  input  1  registered result from the condition stage
pc  output  ADDR_W  current program counter
fetch_en  output  1  fetch may proceed this cycle
flush  output  1  front end must discard the instruction it holds
branch_taken  output  1  one-cycle pulse when a branch is taken
taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Clock port is clk. Reset port is reset_n, synchronous and active-low. Reset has priority over all other inputs.
- Reset values: pc=RESET_PC, state=RUN, cond_sel=2'b11, branch_taken=0, taken_count=0. fetch_en and flush are combinational from state and stall.
- FSM has three states: RUN, ISSUE, RESOLVE.
- RUN:
  - If stall=1: hold everything.
  - Else if instr_valid & is_branch: cond_sel<=cond_code, target_q<=branch_target, next state ISSUE. pc is unchanged.
  - Else if instr_valid: pc<=pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
  - Else: hold.
- ISSUE:
  - cond_sel is stable, and the condition stage samples it at the end of this cycle.
  - Unconditional transition to RESOLVE.
- RESOLVE:
  - cond_true is valid this cycle.
  - If 1: pc<=target_q, branch_taken<=1 for exactly the next cycle, taken_count increments (saturating at all-ones).
  - If 0: pc<=pc+1 (same wrap rule).
  - Next state RUN.
- Branch latency is fixed: the branch is accepted in cycle N, the new pc is visible in cycle N+3, and the sequencer can accept again in N+3.
- stall, instr_valid, is_branch, cond_code and branch_target are ignored in ISSUE and RESOLVE. Branch resolution cannot be stalled.
- fetch_en = (state==RUN) & ~stall.
- flush = (state==ISSUE) | (state==RESOLVE).
- Code 11 still goes through ISSUE/RESOLVE; no fast path.
- A branch whose target equals the current pc is legal and reloads the same pc.
- Reset mid-branch (in ISSUE or RESOLVE) abandons the branch. No branch_taken pulse and no counter update.
- cond_sel holds its last value while in RUN between branches.

Decomposition:
- Shared package: condition-code constants (COND_GT=00, COND_LT=01, COND_EQ=10, COND_AL=11) and FSM state encodings (RUN=0, ISSUE=1, RESOLVE=2). The condition stage uses the same code constants.
- Natural sub-module: sat_counter (parameterised width, enable, synchronous active-low reset), used for taken_count.

Test Plan:
- Reset, then 4 cycles of instr_valid=1, is_branch=0 -> pc steps 0,1,2,3,4; fetch_en=1; flush=0.
- pc=0xFF with a non-branch instruction -> pc=0x00 the next cycle; no other output changes.
- At pc=5, branch cond_code=11, target=0x40, cond_true=1 in RESOLVE -> flush high for 2 cycles; pc=0x40 three cycles after acceptance; branch_taken pulses once; taken_count=1.
- At pc=5, branch cond_code=10, target=0x40, cond_true=0 -> pc=6 three cycles after acceptance; no branch_taken pulse; taken_count unchanged.
- stall=1 in RUN with a pending branch -> nothing accepted, pc held, fetch_en=0. stall=1 asserted during ISSUE -> resolution completes on schedule.
- reset_n=0 in RESOLVE with cond_true=1 -> next cycle pc=RESET_PC, state RUN, branch_taken=0, taken_count=0.
- With CNT_W=2, take 5 branches -> taken_count stops at 3.
